// File: rtl/fdma_arb_pkg.sv
// Shared types for the FDMA channel arbiter: FSM state encoding and round-robin step.
// No logic of its own; imported by both direction slices.
package fdma_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fdma_arb_dir.sv
// One direction of the arbiter: per-channel pending slots, round-robin grant, strobe gating, data mux.
// Request to pkg_areq is 2 cycles when idle; a busy engine simply leaves requests parked in their slot.
module fdma_arb_dir
  import fdma_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                       ui_clk,
  input  logic                       ui_rstn,
  input  logic [NUM_CH-1:0]          ch_areq,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_size,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_en,
  output logic [NUM_CH-1:0]          ch_last,
  output logic                       pkg_areq,
  output logic [ADDR_W-1:0]          pkg_addr,
  output logic [ADDR_W-1:0]          pkg_size,
  output logic [DATA_W-1:0]          pkg_data,
  input  logic                       pkg_en,
  input  logic                       pkg_last,
  output logic [NUM_CH-1:0]          ovf
);

  localparam int GW = $clog2(NUM_CH);

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] pend;
  logic [ADDR_W-1:0] slot_addr [NUM_CH];
  logic [ADDR_W-1:0] slot_size [NUM_CH];
  logic [ADDR_W-1:0] in_addr   [NUM_CH];
  logic [ADDR_W-1:0] in_size   [NUM_CH];
  logic [DATA_W-1:0] in_data   [NUM_CH];
  logic [GW-1:0]     gnt, last_gnt, sel;
  logic              sel_vld, grant;
  int unsigned       rr_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign in_addr[i] = ch_addr[i*ADDR_W +: ADDR_W];
    assign in_size[i] = ch_size[i*ADDR_W +: ADDR_W];
    assign in_data[i] = ch_data[i*DATA_W +: DATA_W];
  end

  // First pending channel strictly after the previous winner, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    rr_idx  = 32'(last_gnt);
    for (int k = 0; k < NUM_CH; k++) begin
      rr_idx = rr_next(rr_idx, NUM_CH);
      if (!sel_vld && pend[rr_idx[GW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = rr_idx[GW-1:0];
      end
    end
  end

  assign grant = (state == S_IDLE) && sel_vld;

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_BUSY;
      S_BUSY:  if (pkg_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ch_en    = '0;
    ch_last  = '0;
    pkg_areq = (state == S_ISSUE);
    if (state == S_BUSY) begin
      ch_en[gnt]   = pkg_en;
      ch_last[gnt] = pkg_last;
    end
  end

  assign pkg_data = in_data[gnt];

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      gnt      <= '0;
      last_gnt <= GW'(NUM_CH - 1);
      pkg_addr <= '0;
      pkg_size <= '0;
    end else begin
      if (grant) begin
        gnt      <= sel;
        pkg_addr <= slot_addr[sel];
        pkg_size <= slot_size[sel];
      end
      if (state == S_BUSY && pkg_last) last_gnt <= gnt;
    end
  end

  // A slot being granted this cycle is free again, so a coincident areq refills it cleanly.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      pend <= '0;
      ovf  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_addr[i] <= '0;
        slot_size[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_areq[i] && (!pend[i] || (grant && sel == GW'(i)))) begin
          pend[i]      <= 1'b1;
          slot_addr[i] <= in_addr[i];
          slot_size[i] <= in_size[i];
        end else if (grant && sel == GW'(i)) begin
          pend[i] <= 1'b0;
        end
        if (ch_areq[i] && pend[i] && !(grant && sel == GW'(i))) ovf[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdma_arbiter.sv
// Shares one FDMA engine's write and read channels among NUM_CH frame-buffer controllers.
// Each direction is an independent round-robin slice; read data is broadcast without muxing.
module fdma_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                     ui_clk,
  input  logic                     ui_rstn,
  input  logic [NUM_CH-1:0]        ch_wr_areq,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_size,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        ch_wr_en,
  output logic [NUM_CH-1:0]        ch_wr_last,
  input  logic [NUM_CH-1:0]        ch_rd_areq,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_size,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [NUM_CH-1:0]        ch_rd_last,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic                     pkg_wr_areq,
  output logic [ADDR_W-1:0]        pkg_wr_addr,
  output logic [ADDR_W-1:0]        pkg_wr_size,
  output logic [DATA_W-1:0]        pkg_wr_data,
  input  logic                     pkg_wr_en,
  input  logic                     pkg_wr_last,
  output logic                     pkg_rd_areq,
  output logic [ADDR_W-1:0]        pkg_rd_addr,
  output logic [ADDR_W-1:0]        pkg_rd_size,
  input  logic                     pkg_rd_en,
  input  logic                     pkg_rd_last,
  input  logic [DATA_W-1:0]        pkg_rd_data,
  output logic [NUM_CH-1:0]        wr_ovf,
  output logic [NUM_CH-1:0]        rd_ovf
);

  logic [DATA_W-1:0] rd_mux_unused;

  fdma_arb_dir #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .ui_clk   (ui_clk),
    .ui_rstn  (ui_rstn),
    .ch_areq  (ch_wr_areq),
    .ch_addr  (ch_wr_addr),
    .ch_size  (ch_wr_size),
    .ch_data  (ch_wr_data),
    .ch_en    (ch_wr_en),
    .ch_last  (ch_wr_last),
    .pkg_areq (pkg_wr_areq),
    .pkg_addr (pkg_wr_addr),
    .pkg_size (pkg_wr_size),
    .pkg_data (pkg_wr_data),
    .pkg_en   (pkg_wr_en),
    .pkg_last (pkg_wr_last),
    .ovf      (wr_ovf)
  );

  fdma_arb_dir #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
    .ui_clk   (ui_clk),
    .ui_rstn  (ui_rstn),
    .ch_areq  (ch_rd_areq),
    .ch_addr  (ch_rd_addr),
    .ch_size  (ch_rd_size),
    .ch_data  ('0),
    .ch_en    (ch_rd_en),
    .ch_last  (ch_rd_last),
    .pkg_areq (pkg_rd_areq),
    .pkg_addr (pkg_rd_addr),
    .pkg_size (pkg_rd_size),
    .pkg_data (rd_mux_unused),
    .pkg_en   (pkg_rd_en),
    .pkg_last (pkg_rd_last),
    .ovf      (rd_ovf)
  );

  assign ch_rd_data = pkg_rd_data;

endmodule

// File: tb/tb_fdma_arbiter.sv
// Bench for fdma_arbiter: directed requests push expected grants into per-direction queues,
// a negedge monitor pops and checks them, plus strobe gating and data routing every active cycle.
module tb_fdma_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int M_ABS   = 0;  // areq expected exactly 2 cycles after the request pulse
  localparam int M_AFTER = 1;  // areq expected exactly 2 cycles after the previous last

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] size;
    int          mode;
    int          exp_cyc;
  } exp_t;

  logic                     ui_clk = 1'b0;
  logic                     ui_rstn;
  logic [NUM_CH-1:0]        ch_wr_areq, ch_rd_areq;
  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr, ch_wr_size, ch_rd_addr, ch_rd_size;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [NUM_CH-1:0]        ch_wr_en, ch_wr_last, ch_rd_en, ch_rd_last;
  logic [DATA_W-1:0]        ch_rd_data, pkg_wr_data, pkg_rd_data;
  logic                     pkg_wr_areq, pkg_rd_areq;
  logic [ADDR_W-1:0]        pkg_wr_addr, pkg_wr_size, pkg_rd_addr, pkg_rd_size;
  logic                     pkg_wr_en, pkg_wr_last, pkg_rd_en, pkg_rd_last;
  logic [NUM_CH-1:0]        wr_ovf, rd_ovf;

  fdma_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn),
    .ch_wr_areq(ch_wr_areq), .ch_wr_addr(ch_wr_addr), .ch_wr_size(ch_wr_size), .ch_wr_data(ch_wr_data),
    .ch_wr_en(ch_wr_en), .ch_wr_last(ch_wr_last),
    .ch_rd_areq(ch_rd_areq), .ch_rd_addr(ch_rd_addr), .ch_rd_size(ch_rd_size),
    .ch_rd_en(ch_rd_en), .ch_rd_last(ch_rd_last), .ch_rd_data(ch_rd_data),
    .pkg_wr_areq(pkg_wr_areq), .pkg_wr_addr(pkg_wr_addr), .pkg_wr_size(pkg_wr_size), .pkg_wr_data(pkg_wr_data),
    .pkg_wr_en(pkg_wr_en), .pkg_wr_last(pkg_wr_last),
    .pkg_rd_areq(pkg_rd_areq), .pkg_rd_addr(pkg_rd_addr), .pkg_rd_size(pkg_rd_size),
    .pkg_rd_en(pkg_rd_en), .pkg_rd_last(pkg_rd_last), .pkg_rd_data(pkg_rd_data),
    .wr_ovf(wr_ovf), .rd_ovf(rd_ovf)
  );

  always #5 ui_clk = ~ui_clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t wr_q[$];
  exp_t rd_q[$];
  logic [1:0] mbusy = '0;
  logic [1:0] stray = '0;
  int   cur[2];
  int   last_cyc[2];
  int   rem[2];
  int   wr_ch0_pulses = 0;

  always @(posedge ui_clk) cyc <= cyc + 1;

  logic [1:0]        m_areq, m_en, m_last;
  logic [NUM_CH-1:0] m_chen [2];
  logic [NUM_CH-1:0] m_chlast [2];
  logic [31:0]       m_addr [2];
  logic [31:0]       m_size [2];
  assign m_areq = {pkg_rd_areq, pkg_wr_areq};
  assign m_en   = {pkg_rd_en, pkg_wr_en};
  assign m_last = {pkg_rd_last, pkg_wr_last};
  assign m_chen[0] = ch_wr_en;     assign m_chen[1] = ch_rd_en;
  assign m_chlast[0] = ch_wr_last; assign m_chlast[1] = ch_rd_last;
  assign m_addr[0] = pkg_wr_addr;  assign m_addr[1] = pkg_rd_addr;
  assign m_size[0] = pkg_wr_size;  assign m_size[1] = pkg_rd_size;

  function automatic logic [127:0] wd(input int ch);
    logic [31:0] w;
    w = 32'hD0D0_0000 + 32'(ch);
    return {4{w}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: size pulses of en, last on the final one, starting the cycle after areq.
  initial begin
    pkg_wr_en = 0; pkg_wr_last = 0; pkg_rd_en = 0; pkg_rd_last = 0; pkg_rd_data = '0;
    rem[0] = 0; rem[1] = 0;
    forever begin
      @(negedge ui_clk);
      for (int d = 0; d < 2; d++) begin
        if (!ui_rstn) rem[d] = 0;
        else if (m_areq[d]) rem[d] = int'(m_size[d]);
      end
      @(posedge ui_clk);
      #2;
      if (!ui_rstn) begin rem[0] = 0; rem[1] = 0; end
      pkg_wr_en   = (rem[0] > 0) || stray[0];
      pkg_wr_last = (rem[0] == 1);
      pkg_rd_en   = (rem[1] > 0) || stray[1];
      pkg_rd_last = (rem[1] == 1);
      pkg_rd_data = {4{32'(cyc)}} ^ 128'hA5A5_0000_5A5A_0000_1234_0000_0000_FFFF;
      for (int d = 0; d < 2; d++) if (rem[d] > 0) rem[d]--;
    end
  end

  // Monitor: strobe gating, data routing, and in-order grant checking against the queues.
  initial begin
    forever begin
      @(negedge ui_clk);
      if (!ui_rstn) begin
        mbusy = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          logic [NUM_CH-1:0] xen, xlast;
          exp_t e;
          xen   = mbusy[d] ? (NUM_CH'(m_en[d]) << cur[d]) : '0;
          xlast = mbusy[d] ? (NUM_CH'(m_last[d]) << cur[d]) : '0;
          if (m_en[d] || m_last[d] || m_chen[d] != 0 || m_chlast[d] != 0) begin
            chk(d == 0 ? "wr_ch_en" : "rd_ch_en", m_chen[d], xen);
            chk(d == 0 ? "wr_ch_last" : "rd_ch_last", m_chlast[d], xlast);
          end
          if (d == 0 && ch_wr_en[0]) wr_ch0_pulses++;
          if (mbusy[d] && m_en[d]) begin
            if (d == 0) chk("wr_data_mux", pkg_wr_data, wd(cur[0]));
            else        chk("rd_data_bcast", ch_rd_data, pkg_rd_data);
          end
          if (mbusy[d] && m_last[d]) begin
            mbusy[d]    = 1'b0;
            last_cyc[d] = cyc;
          end
          if (m_areq[d]) begin
            if ((d == 0 && wr_q.size() == 0) || (d == 1 && rd_q.size() == 0)) begin
              checks++; errors++;
              $display("FAIL %s_unexpected_areq: got request addr 0x%0h, expected none", d == 0 ? "wr" : "rd", m_addr[d]);
            end else begin
              if (d == 0) e = wr_q.pop_front();
              else        e = rd_q.pop_front();
              chk(d == 0 ? "wr_pkg_addr" : "rd_pkg_addr", m_addr[d], e.addr);
              chk(d == 0 ? "wr_pkg_size" : "rd_pkg_size", m_size[d], e.size);
              chk(d == 0 ? "wr_areq_cycle" : "rd_areq_cycle", cyc,
                  (e.mode == M_ABS) ? e.exp_cyc : last_cyc[d] + 2);
              cur[d]   = e.ch;
              mbusy[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic set_req(input int d, input int ch, input logic [31:0] addr, input logic [31:0] size,
                         input int mode, input bit push);
    exp_t e;
    if (d == 0) begin
      ch_wr_areq[ch] = 1'b1; ch_wr_addr[ch*32 +: 32] = addr; ch_wr_size[ch*32 +: 32] = size;
    end else begin
      ch_rd_areq[ch] = 1'b1; ch_rd_addr[ch*32 +: 32] = addr; ch_rd_size[ch*32 +: 32] = size;
    end
    if (push) begin
      e.ch = ch; e.addr = addr; e.size = size; e.mode = mode; e.exp_cyc = cyc + 2;
      if (d == 0) wr_q.push_back(e);
      else        rd_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
    ch_wr_areq = '0;
    ch_rd_areq = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (n < maxc && !(wr_q.size() == 0 && rd_q.size() == 0 && mbusy == 2'b00)) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL wait_idle: got still busy after %0d cycles, expected drained", n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ui_rstn = 1'b1;
    ch_wr_areq = '0; ch_rd_areq = '0;
    ch_wr_addr = '0; ch_wr_size = '0; ch_rd_addr = '0; ch_rd_size = '0;
    ch_wr_data = {wd(1), wd(0)};
    #2 ui_rstn = 1'b0;
    #1;
    chk("rst_pkg_wr_areq", pkg_wr_areq, 1'b0);
    chk("rst_pkg_rd_areq", pkg_rd_areq, 1'b0);
    chk("rst_pkg_wr_addr", pkg_wr_addr, 32'h0);
    chk("rst_pkg_wr_size", pkg_wr_size, 32'h0);
    chk("rst_ch_wr_en", ch_wr_en, 2'b00);
    chk("rst_ovf", {wr_ovf, rd_ovf}, 4'b0000);
    cycles(3);
    ui_rstn = 1'b1;
    cycles(2);

    // Single request on ch0, 256 beats, all routed to ch0 only.
    wr_ch0_pulses = 0;
    set_req(0, 0, 32'h0000_1000, 32'd256, M_ABS, 1'b1);
    tick();
    wait_idle(400);
    chk("wr_ch0_pulse_count", wr_ch0_pulses, 32'd256);

    // Engine strobes while idle must not reach any channel.
    stray[0] = 1'b1;
    tick();
    stray[0] = 1'b0;
    cycles(2);

    // Simultaneous ch0+ch1: ch0 just won, so round-robin serves ch1 first.
    set_req(0, 1, 32'h0000_3000, 32'd8, M_ABS, 1'b1);
    set_req(0, 0, 32'h0000_2000, 32'd8, M_AFTER, 1'b1);
    tick();
    wait_idle(100);

    // Fairness: both re-request on every last; 8 packages must alternate.
    set_req(0, 1, 32'h0000_4100, 32'd4, M_ABS, 1'b1);
    set_req(0, 0, 32'h0000_4000, 32'd4, M_AFTER, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      int n;
      int w;
      n = 0;
      do begin
        @(negedge ui_clk);
        n++;
      end while (ch_wr_last == 2'b00 && n < 200);
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL fair_last_wait: got no ch_wr_last in %0d cycles, expected one", n);
      end
      w = ch_wr_last[1] ? 1 : 0;
      @(posedge ui_clk);
      #1;
      set_req(0, w, 32'h0000_4000 + 32'(w) * 32'h100 + 32'(k + 1) * 32'h10, 32'd4, M_AFTER, 1'b1);
      tick();
    end
    wait_idle(200);

    // Overflow: ch1 requests twice while ch0 is busy; only the first is kept.
    set_req(0, 0, 32'h0000_5000, 32'd16, M_ABS, 1'b1);
    tick();
    cycles(4);
    set_req(0, 1, 32'h0000_6000, 32'd4, M_AFTER, 1'b1);
    tick();
    set_req(0, 1, 32'h0000_7000, 32'd4, M_AFTER, 1'b0);
    tick();
    chk("wr_ovf_after_double", wr_ovf, 2'b10);
    chk("rd_ovf_untouched", rd_ovf, 2'b00);
    wait_idle(100);

    // Read request on ch1 while write ch0 is busy.
    set_req(0, 0, 32'h0000_8000, 32'd64, M_ABS, 1'b1);
    tick();
    cycles(5);
    set_req(1, 1, 32'h0000_9000, 32'd8, M_ABS, 1'b1);
    tick();
    wait_idle(200);

    // Reset mid-package with ch1 pending: everything drops and the pending request is lost.
    set_req(0, 0, 32'h0000_A000, 32'd32, M_ABS, 1'b1);
    tick();
    cycles(6);
    set_req(0, 1, 32'h0000_B000, 32'd4, M_AFTER, 1'b0);
    tick();
    cycles(2);
    #2;
    chk("pre_rst_ch_wr_en", ch_wr_en, 2'b01);
    chk("wr_ovf_sticky", wr_ovf, 2'b10);
    ui_rstn = 1'b0;
    wr_q.delete();
    #1;
    chk("arst_ch_wr_en", ch_wr_en, 2'b00);
    chk("arst_pkg_wr_addr", pkg_wr_addr, 32'h0);
    chk("arst_pkg_wr_size", pkg_wr_size, 32'h0);
    chk("arst_wr_ovf", wr_ovf, 2'b00);
    repeat (3) @(posedge ui_clk);
    #1 ui_rstn = 1'b1;
    cycles(20);
    chk("post_rst_no_areq", pkg_wr_areq, 1'b0);

    // After reset channel 0 has priority.
    set_req(0, 0, 32'h0000_C000, 32'd4, M_ABS, 1'b1);
    set_req(0, 1, 32'h0000_D000, 32'd4, M_AFTER, 1'b1);
    tick();
    wait_idle(100);
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
